// File: rtl/ysyx_23060025_axi_rd_slave_pkg.sv
// Shared AXI encodings and FSM state type for the AXI read-channel responder.
package ysyx_23060025_axi_rd_slave_pkg;

  localparam logic [2:0] AXI_ADDR_SIZE_4 = 3'b010;

  localparam logic [1:0] AXI_ADDR_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_ADDR_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_ADDR_BURST_WRAP  = 2'b10;
  localparam logic [1:0] AXI_ADDR_BURST_RSVD  = 2'b11;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST
  } rd_state_e;

  // AXI only allows wrapping bursts of 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/ysyx_23060025_sram_array.sv
// Word-organised memory: one combinational read port, one synchronous write port.
module ysyx_23060025_sram_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // Contents survive reset; the image is loaded through the write port.
  always_ff @(posedge clock) begin
    if (wen) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_23060025_axi_rd_slave.sv
// AXI4 read responder serving icache refills from on-chip memory after a fixed latency.
module ysyx_23060025_axi_rd_slave
  import ysyx_23060025_axi_rd_slave_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_ADDR_W = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] in_araddr,
  input  logic                  in_arvalid,
  output logic                  in_arready,
  input  logic [7:0]            in_arlen,
  input  logic [2:0]            in_arsize,
  input  logic [1:0]            in_arburst,
  output logic                  in_rvalid,
  output logic                  in_rlast,
  output logic [DATA_WIDTH-1:0] in_rdata,
  output logic [1:0]            in_rresp,
  input  logic                  in_rready,
  input  logic                  bd_wen,
  input  logic [MEM_ADDR_W-1:0] bd_waddr,
  input  logic [DATA_WIDTH-1:0] bd_wdata
);

  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(4 * (2 ** MEM_ADDR_W));
  localparam logic [3:0]            LAT_INIT  = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  rd_state_e             state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n, next_addr, offset, wrap_mask;
  logic [7:0]            len_q, len_n, beat_q, beat_n;
  logic [1:0]            burst_q, burst_n;
  logic                  err_q, err_n;
  logic [3:0]            lat_q, lat_n;
  logic                  in_range, beat_err;
  logic [MEM_ADDR_W-1:0] word_idx;
  logic [DATA_WIDTH-1:0] mem_rdata;

  ysyx_23060025_sram_array #(
    .ADDR_W(MEM_ADDR_W),
    .DATA_W(DATA_WIDTH)
  ) u_sram (
    .clock (clock),
    .wen   (bd_wen),
    .waddr (bd_waddr),
    .wdata (bd_wdata),
    .raddr (word_idx),
    .rdata (mem_rdata)
  );

  // Unsigned offset from the base also catches addresses below the base via wraparound.
  assign offset    = addr_q - BASE_ADDR;
  assign in_range  = offset < MEM_BYTES;
  assign word_idx  = offset[MEM_ADDR_W+1:2];
  assign beat_err  = err_q || !in_range;
  assign wrap_mask = ADDR_WIDTH'({len_q, 2'b11});

  always_comb begin
    next_addr = addr_q + ADDR_WIDTH'(4);
    case (burst_q)
      AXI_ADDR_BURST_FIXED: next_addr = addr_q;
      AXI_ADDR_BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) |
                                        ((addr_q + ADDR_WIDTH'(4)) & wrap_mask);
      default:              next_addr = addr_q + ADDR_WIDTH'(4);
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      burst_q <= AXI_ADDR_BURST_FIXED;
      err_q   <= 1'b0;
      lat_q   <= '0;
    end else begin
      state   <= state_n;
      addr_q  <= addr_n;
      len_q   <= len_n;
      beat_q  <= beat_n;
      burst_q <= burst_n;
      err_q   <= err_n;
      lat_q   <= lat_n;
    end
  end

  always_comb begin
    state_n    = state;
    addr_n     = addr_q;
    len_n      = len_q;
    beat_n     = beat_q;
    burst_n    = burst_q;
    err_n      = err_q;
    lat_n      = lat_q;
    in_arready = 1'b0;
    in_rvalid  = 1'b0;
    in_rlast   = 1'b0;
    in_rdata   = '0;
    in_rresp   = AXI_RESP_OKAY;
    case (state)
      ST_IDLE: begin
        in_arready = !reset;
        if (in_arvalid) begin
          addr_n  = in_araddr & ~ADDR_WIDTH'(3);
          len_n   = in_arlen;
          burst_n = in_arburst;
          beat_n  = '0;
          err_n   = (in_arsize != AXI_ADDR_SIZE_4) ||
                    (in_arburst == AXI_ADDR_BURST_RSVD) ||
                    ((in_arburst == AXI_ADDR_BURST_WRAP) && !wrap_len_ok(in_arlen));
          if (LATENCY == 0) begin
            state_n = ST_BURST;
          end else begin
            state_n = ST_WAIT;
            lat_n   = LAT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (lat_q == 4'd0) state_n = ST_BURST;
        else               lat_n   = lat_q - 4'd1;
      end
      ST_BURST: begin
        in_rvalid = 1'b1;
        in_rlast  = (beat_q == len_q);
        in_rdata  = beat_err ? '0 : mem_rdata;
        in_rresp  = beat_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        if (in_rready) begin
          if (beat_q == len_q) begin
            state_n = ST_IDLE;
          end else begin
            beat_n = beat_q + 8'd1;
            addr_n = next_addr;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060025_axi_rd_slave.sv
// Self-checking bench: directed refill scenarios plus randomized bursts against a memory model.
module tb_ysyx_23060025_axi_rd_slave;

  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_araddr;
  logic        in_arvalid, in_arready;
  logic [7:0]  in_arlen;
  logic [2:0]  in_arsize;
  logic [1:0]  in_arburst;
  logic        in_rvalid, in_rlast, in_rready;
  logic [31:0] in_rdata;
  logic [1:0]  in_rresp;
  logic        bd_wen;
  logic [9:0]  bd_waddr;
  logic [31:0] bd_wdata;

  logic [31:0] z_araddr, z_rdata;
  logic        z_arvalid, z_arready, z_rvalid, z_rlast, z_rready;
  logic [1:0]  z_rresp;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] ref_mem [0:1023];

  always #5 clock = ~clock;

  ysyx_23060025_axi_rd_slave #(.LATENCY(LAT)) u_dut (
    .clock(clock), .reset(reset),
    .in_araddr(in_araddr), .in_arvalid(in_arvalid), .in_arready(in_arready),
    .in_arlen(in_arlen), .in_arsize(in_arsize), .in_arburst(in_arburst),
    .in_rvalid(in_rvalid), .in_rlast(in_rlast), .in_rdata(in_rdata),
    .in_rresp(in_rresp), .in_rready(in_rready),
    .bd_wen(bd_wen), .bd_waddr(bd_waddr), .bd_wdata(bd_wdata)
  );

  ysyx_23060025_axi_rd_slave #(.LATENCY(0)) u_dut0 (
    .clock(clock), .reset(reset),
    .in_araddr(z_araddr), .in_arvalid(z_arvalid), .in_arready(z_arready),
    .in_arlen(8'd0), .in_arsize(3'd2), .in_arburst(2'b01),
    .in_rvalid(z_rvalid), .in_rlast(z_rlast), .in_rdata(z_rdata),
    .in_rresp(z_rresp), .in_rready(z_rready),
    .bd_wen(bd_wen), .bd_waddr(bd_waddr), .bd_wdata(bd_wdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: per-beat address from the burst rules, then range and legality checks.
  function automatic void modelBeat(input logic [31:0] start, input int len, input int size,
                                    input int burst, input int i,
                                    output logic [31:0] data, output logic [1:0] resp);
    longint unsigned s, a, blk, lo;
    bit bad;
    s   = longint'(start) & 64'hFFFF_FFFC;
    bad = (size != 2) || (burst == 3) ||
          (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    case (burst)
      0: a = s;
      2: begin
        blk = longint'(len + 1) * 4;
        lo  = s - (s % blk);
        a   = lo + ((s - lo + 4 * i) % blk);
      end
      default: a = (s + 4 * i) % 64'h1_0000_0000;
    endcase
    if (bad || a < 64'(BASE) || a >= 64'(BASE) + 4096) begin
      data = 32'h0;
      resp = 2'b10;
    end else begin
      data = ref_mem[int'((a - 64'(BASE)) / 4)];
      resp = 2'b00;
    end
  endfunction

  task automatic bdWrite(input int idx, input logic [31:0] data);
    @(negedge clock);
    bd_wen   = 1'b1;
    bd_waddr = 10'(idx);
    bd_wdata = data;
    @(negedge clock);
    bd_wen = 1'b0;
    ref_mem[idx] = data;
  endtask

  // mode 0: rready held high, 1: toggles 0/1 starting low, 2: random per cycle
  task automatic applyStimulus(input logic [31:0] addr, input int len, input int size,
                               input int burst, input int mode, input string tag);
    logic [31:0] ed;
    logic [1:0]  er;
    int beat, cyc, waited;
    @(negedge clock);
    checkOutput({tag, ".arready_idle"}, 32'(in_arready), 32'd1);
    in_araddr  = addr;
    in_arlen   = 8'(len);
    in_arsize  = 3'(size);
    in_arburst = 2'(burst);
    in_arvalid = 1'b1;
    @(negedge clock);
    in_arvalid = 1'b0;
    checkOutput({tag, ".arready_busy"}, 32'(in_arready), 32'd0);
    waited = 0;
    while (!in_rvalid && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    checkOutput({tag, ".latency"}, 32'(waited), 32'(LAT));
    if (!in_rvalid) return;
    beat = 0;
    cyc  = 0;
    while (beat <= len && cyc < 200) begin
      case (mode)
        0:       in_rready = 1'b1;
        1:       in_rready = (cyc % 2) == 1;
        default: in_rready = 1'($urandom_range(0, 1));
      endcase
      modelBeat(addr, len, size, burst, beat, ed, er);
      checkOutput({tag, ".rvalid"}, 32'(in_rvalid), 32'd1);
      checkOutput({tag, ".rdata"}, in_rdata, ed);
      checkOutput({tag, ".rresp"}, 32'(in_rresp), 32'(er));
      checkOutput({tag, ".rlast"}, 32'(in_rlast), 32'(beat == len));
      @(posedge clock);
      if (in_rready) beat++;
      cyc++;
      @(negedge clock);
    end
    in_rready = 1'b0;
    checkOutput({tag, ".beats"}, 32'(beat), 32'(len + 1));
    if (mode == 0) checkOutput({tag, ".cycles"}, 32'(cyc), 32'(len + 1));
    if (mode == 1) checkOutput({tag, ".cycles"}, 32'(cyc), 32'(2 * (len + 1)));
    checkOutput({tag, ".rvalid_after"}, 32'(in_rvalid), 32'd0);
    checkOutput({tag, ".arready_after"}, 32'(in_arready), 32'd1);
  endtask

  initial begin
    int sw, bt;
    reset = 1'b1;
    in_araddr = '0; in_arvalid = 1'b0; in_arlen = '0; in_arsize = 3'd2; in_arburst = 2'b01;
    in_rready = 1'b0; bd_wen = 1'b0; bd_waddr = '0; bd_wdata = '0;
    z_araddr = '0; z_arvalid = 1'b0; z_rready = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("reset.arready", 32'(in_arready), 32'd0);
    checkOutput("reset.rvalid", 32'(in_rvalid), 32'd0);
    checkOutput("reset.rlast", 32'(in_rlast), 32'd0);
    checkOutput("reset.rresp", 32'(in_rresp), 32'd0);
    checkOutput("reset.rdata", in_rdata, 32'd0);
    reset = 1'b0;
    #1 checkOutput("post_reset.arready", 32'(in_arready), 32'd1);

    bdWrite(0, 32'h11); bdWrite(1, 32'h22); bdWrite(2, 32'h33); bdWrite(3, 32'h44);
    for (int i = 4; i < 64; i++) bdWrite(i, $urandom);
    for (int i = 1008; i < 1024; i++) bdWrite(i, $urandom);

    applyStimulus(BASE, 3, 2, 1, 0, "incr4");
    applyStimulus(BASE + 32'h8, 3, 2, 2, 0, "wrap4");
    applyStimulus(BASE, 3, 2, 1, 1, "stall4");
    applyStimulus(32'h7FFF_FFFC, 1, 2, 1, 0, "below_base");
    applyStimulus(32'h7FFF_FFFC, 1, 3, 1, 0, "bad_size");
    applyStimulus(BASE + 32'hFF8, 3, 2, 1, 0, "past_top");
    applyStimulus(BASE + 32'h10, 4, 2, 2, 0, "wrap_badlen");

    // Reset in the middle of a burst abandons it.
    @(negedge clock);
    in_araddr = BASE; in_arlen = 8'd3; in_arsize = 3'd2; in_arburst = 2'b01; in_arvalid = 1'b1;
    @(negedge clock);
    in_arvalid = 1'b0;
    in_rready  = 1'b1;
    repeat (LAT) @(negedge clock);
    checkOutput("rst_mid.beat0", in_rdata, ref_mem[0]);
    @(negedge clock);
    checkOutput("rst_mid.beat1", in_rdata, ref_mem[1]);
    @(negedge clock);
    reset = 1'b1;
    #1 checkOutput("rst_mid.arready_in_reset", 32'(in_arready), 32'd0);
    @(negedge clock);
    checkOutput("rst_mid.rvalid", 32'(in_rvalid), 32'd0);
    checkOutput("rst_mid.rlast", 32'(in_rlast), 32'd0);
    reset     = 1'b0;
    in_rready = 1'b0;
    #1 checkOutput("rst_mid.arready", 32'(in_arready), 32'd1);
    applyStimulus(BASE + 32'h4, 0, 2, 1, 0, "rst_fresh");

    // Zero-latency instance: two back-to-back single-beat reads.
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      checkOutput("lat0.arready_idle", 32'(z_arready), 32'd1);
      z_araddr  = BASE + 32'(12 * k);
      z_arvalid = 1'b1;
      @(negedge clock);
      z_arvalid = 1'b0;
      z_rready  = 1'b1;
      checkOutput("lat0.rvalid", 32'(z_rvalid), 32'd1);
      checkOutput("lat0.rdata", z_rdata, ref_mem[3 * k]);
      checkOutput("lat0.rlast", 32'(z_rlast), 32'd1);
      checkOutput("lat0.rresp", 32'(z_rresp), 32'd0);
      checkOutput("lat0.arready_busy", 32'(z_arready), 32'd0);
      @(negedge clock);
      z_rready = 1'b0;
      checkOutput("lat0.rvalid_after", 32'(z_rvalid), 32'd0);
      checkOutput("lat0.arready_after", 32'(z_arready), 32'd1);
    end

    for (int n = 0; n < 30; n++) begin
      sw = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 48) : $urandom_range(1008, 1023);
      bt = $urandom_range(0, 3);
      applyStimulus(BASE + 32'(4 * sw), $urandom_range(0, 15),
                    ($urandom_range(0, 7) == 0) ? 3 : 2, bt, 2, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
